memory: RTL and testbench

// - Behavioural main-memory model on the cache<->memory bus (bus 2), driven by the cache.
// - Serves whole-line reads and writes with fixed latency, transferring lines over a narrow data bus in beats.
// - Companion free-running clock source (clock_gen) drives clk for the whole subsystem.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/memory.sv | 146 ++++++++++++++
 tb/tb_memory.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the cache<->memory bus: command encoding, line geometry
// and the power-up content pattern of the main-memory model.
package mem_pkg;

    localparam int unsigned BITS_IN_BYTE = 8;
    localparam int unsigned LINE_BYTES   = 16;
    localparam int unsigned DATA_BYTES   = 2;
    localparam int unsigned ADDR_W       = 15;
    localparam int unsigned MEM_LATENCY  = 100;
    localparam int unsigned CLK_HALF     = 1;

    localparam int unsigned LINE_W = LINE_BYTES * BITS_IN_BYTE;
    localparam int unsigned DATA_W = DATA_BYTES * BITS_IN_BYTE;
    localparam int unsigned BEATS  = LINE_BYTES / DATA_BYTES;
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned LAT_W  = $clog2(MEM_LATENCY + 1);
    localparam int unsigned OFFS_W = $clog2(LINE_BYTES);
    localparam int unsigned LINES  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CAPTURE,
        ST_WAIT,
        ST_RESPOND_RD,
        ST_RESPOND_WR
    } mem_state_e;

    // Power-up content of a line: every byte holds the low 8 bits of its byte address.
    function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_W-1:0] line);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int unsigned j = 0; j < LINE_BYTES; j++) begin
            l[j*BITS_IN_BYTE +: BITS_IN_BYTE] = BITS_IN_BYTE'({line, OFFS_W'(j)});
        end
        return l;
    endfunction

endpackage

// File: rtl/memory.sv
// Main-memory model on the cache<->memory bus: whole-line reads and writes with a
// fixed latency, lines moved over a narrow shared data bus in little-endian beats.
module memory
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              dump,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    inout  wire  [1:0]        cmd
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_wr_q, is_wr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              cmd_en_q, cmd_en_d;
    logic              data_en_q, data_en_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mem_we_c;
    logic [LINE_W-1:0] rd_line_c;

    // Array holds the difference from the power-up pattern, so a cleared array reads as that pattern.
    logic [LINE_W-1:0] store_q [LINES];

    logic unused_dump;
    assign unused_dump = dump;

    assign rd_line_c = store_q[addr_q] ^ init_line(addr_q);

    assign cmd  = cmd_en_q  ? 2'(C2_RESPONSE) : 2'bzz;
    assign data = data_en_q ? data_q : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            is_wr_q   <= 1'b0;
            beat_q    <= '0;
            lat_q     <= '0;
            line_q    <= '0;
            cmd_en_q  <= 1'b0;
            data_en_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            is_wr_q   <= is_wr_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            line_q    <= line_d;
            cmd_en_q  <= cmd_en_d;
            data_en_q <= data_en_d;
            data_q    <= data_d;
        end
    end

    // Contents survive reset; only a completed write updates the array.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            store_q[addr_q] <= line_q ^ init_line(addr_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        is_wr_d   = is_wr_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        line_d    = line_q;
        cmd_en_d  = 1'b0;
        data_en_d = 1'b0;
        data_d    = data_q;
        mem_we_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Latency count starts at one: the command edge itself is clock zero.
                lat_d  = LAT_W'(1);
                beat_d = '0;
                if (cmd == C2_READ_LINE) begin
                    addr_d  = addr;
                    is_wr_d = 1'b0;
                    state_d = ST_WAIT;
                end else if (cmd == C2_WRITE_LINE) begin
                    addr_d           = addr;
                    is_wr_d          = 1'b1;
                    line_d[DATA_W-1:0] = data;
                    beat_d           = BEAT_W'(1);
                    state_d          = ST_WR_CAPTURE;
                end
            end

            ST_WR_CAPTURE: begin
                line_d[beat_q*DATA_W +: DATA_W] = data;
                beat_d = BEAT_W'(beat_q + 1'b1);
                lat_d  = LAT_W'(lat_q + 1'b1);
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (lat_q >= LAT_W'(MEM_LATENCY)) begin
                    cmd_en_d = 1'b1;
                    beat_d   = '0;
                    if (is_wr_q) begin
                        mem_we_c = 1'b1;
                        state_d  = ST_RESPOND_WR;
                    end else begin
                        line_d    = rd_line_c;
                        data_d    = rd_line_c[DATA_W-1:0];
                        data_en_d = 1'b1;
                        state_d   = ST_RESPOND_RD;
                    end
                end else begin
                    lat_d = LAT_W'(lat_q + 1'b1);
                end
            end

            ST_RESPOND_RD: begin
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d    = BEAT_W'(beat_q + 1'b1);
                    data_d    = line_q[(beat_q + 1'b1)*DATA_W +: DATA_W];
                    cmd_en_d  = 1'b1;
                    data_en_d = 1'b1;
                end
            end

            ST_RESPOND_WR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory.sv
// Randomized scoreboard bench for the main-memory model: a driver issues line
// commands and queues expected responses, a monitor checks what appears on the bus.
`timescale 1ns/100ps
module tb_memory;
    import mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dump;
    logic [ADDR_W-1:0] addr;
    wire  [DATA_W-1:0] data;
    wire  [1:0]        cmd;

    logic              tb_cmd_en;
    logic [1:0]        tb_cmd;
    logic              tb_data_en;
    logic [DATA_W-1:0] tb_data;

    assign cmd  = tb_cmd_en  ? tb_cmd  : 2'bzz;
    assign data = tb_data_en ? tb_data : {DATA_W{1'bz}};

    always #(CLK_HALF) clk = ~clk;

    memory dut (
        .clk   (clk),
        .reset (rst_n),
        .dump  (dump),
        .addr  (addr),
        .data  (data),
        .cmd   (cmd)
    );

    typedef struct {
        int unsigned       start;
        bit                is_wr;
        logic [LINE_W-1:0] line;
    } exp_t;

    exp_t              exp_q[$];
    logic [LINE_W-1:0] model [int unsigned];
    int unsigned       n_checks = 0;
    int unsigned       n_pass   = 0;
    int unsigned       cyc      = 0;
    bit                in_burst = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    endtask

    // Reference contents: written lines from the model, otherwise byte = address mod 256.
    function automatic logic [LINE_W-1:0] model_line(input int unsigned a);
        logic [LINE_W-1:0] l;
        if (model.exists(a)) return model[a];
        for (int j = 0; j < int'(LINE_BYTES); j++) begin
            l[j*8 +: 8] = 8'((a * LINE_BYTES + 32'(j)) % 256);
        end
        return l;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops an expectation at every response start and follows the burst.
    exp_t        cur;
    int unsigned beat_i;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_burst = 1'b0;
        end else if (in_burst) begin
            if (beat_i < (cur.is_wr ? 1 : BEATS)) begin
                check("rsp_cmd", 64'(cmd), 64'(C2_RESPONSE));
                check("rsp_beat", 64'(data), 64'(cur.line[beat_i*DATA_W +: DATA_W]));
                beat_i++;
            end else begin
                check("bus_release", 64'(cmd == C2_RESPONSE), 64'(0));
                in_burst = 1'b0;
            end
        end else if (cmd == C2_RESPONSE) begin
            check("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("rsp_latency", 64'(cyc), 64'(cur.start));
                if (!cur.is_wr) check("rsp_beat", 64'(data), 64'(cur.line[DATA_W-1:0]));
                beat_i   = 1;
                in_burst = 1'b1;
            end
        end
    end

    task automatic issue_read(input logic [ADDR_W-1:0] a);
        exp_t e;
        @(negedge clk);
        addr      = a;
        tb_cmd    = C2_READ_LINE;
        tb_cmd_en = 1'b1;
        e.start   = cyc + 1 + MEM_LATENCY;
        e.is_wr   = 1'b0;
        e.line    = model_line(32'(a));
        exp_q.push_back(e);
        @(negedge clk);
        tb_cmd_en = 1'b0;
        addr      = ADDR_W'($urandom);
    endtask

    task automatic issue_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] l,
                               input bit expect_rsp);
        exp_t e;
        @(negedge clk);
        addr       = a;
        tb_cmd     = C2_WRITE_LINE;
        tb_cmd_en  = 1'b1;
        tb_data    = l[DATA_W-1:0];
        tb_data_en = 1'b1;
        if (expect_rsp) begin
            e.start = cyc + 1 + MEM_LATENCY;
            e.is_wr = 1'b1;
            e.line  = l;
            exp_q.push_back(e);
        end
        for (int k = 1; k < int'(BEATS); k++) begin
            @(negedge clk);
            tb_cmd_en = 1'b0;
            addr      = ADDR_W'($urandom);
            tb_data   = l[k*DATA_W +: DATA_W];
        end
        @(negedge clk);
        tb_data_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || in_burst) && n < 400) begin
            @(negedge clk);
            #0.2;
            n++;
        end
        check({name, "_done"}, 64'(exp_q.size() != 0 || in_burst), 64'(0));
        @(negedge clk);
    endtask

    task automatic write_line(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] l);
        issue_write(a, l, 1'b1);
        wait_idle("write");
        model[32'(a)] = l;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < int'(LINE_W / 32); i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        #150000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [LINE_W-1:0] wl;
        int unsigned       n;
        logic [ADDR_W-1:0] a;

        rst_n      = 1'b0;
        dump       = 1'b0;
        addr       = '0;
        tb_cmd     = C2_NOP;
        tb_cmd_en  = 1'b0;
        tb_data    = '0;
        tb_data_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cmd_released", 64'(cmd == C2_RESPONSE), 64'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_cmd_released", 64'(cmd == C2_RESPONSE), 64'(0));

        // Power-up pattern on the first lines and the top line.
        issue_read(15'h0000); wait_idle("rd_line0");
        issue_read(15'h0001); wait_idle("rd_line1");
        issue_read(15'h7FFF); wait_idle("rd_top");

        // Directed write then read back.
        wl = '0;
        wl[15:0]  = 16'hEEFF;
        wl[31:16] = 16'h9999;
        write_line(15'h1234, wl);
        issue_read(15'h1234); wait_idle("rd_1234");

        // Reset during write latency aborts the write.
        issue_write(15'h0042, rand_line(), 1'b1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #0.2;
        check("reset_in_wait_cmd", 64'(cmd == C2_RESPONSE), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_read(15'h0042); wait_idle("rd_after_abort");

        // Reset in the middle of a read burst releases the bus at once.
        issue_read(15'h0100);
        n = 0;
        while (!in_burst && n < 300) begin
            @(negedge clk);
            #0.2;
            n++;
        end
        check("burst_started", 64'(in_burst), 64'(1));
        @(posedge clk);
        #0.2;
        check("burst_active", 64'(cmd), 64'(C2_RESPONSE));
        rst_n = 1'b0;
        #0.2;
        check("reset_in_burst_cmd", 64'(cmd == C2_RESPONSE), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);

        // A write issued while a read waits is ignored entirely.
        issue_read(15'h0200);
        repeat (10) @(negedge clk);
        issue_write(15'h0200, rand_line(), 1'b0);
        wait_idle("rd_with_ignored_wr");
        issue_read(15'h0200); wait_idle("rd_after_ignored_wr");

        // Random mix over a small hot set and the full address space.
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 1) == 0) ? ADDR_W'(15'h0010 + $urandom_range(0, 3))
                                            : ADDR_W'($urandom);
            if ($urandom_range(0, 9) < 5) write_line(a, rand_line());
            else begin
                issue_read(a);
                wait_idle("rand_rd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
